ball_motion_ctrl: RTL

Frame-synchronous motion controller for the bouncing-ball sprite in the VGA demo. It advances the ball centre once per N frames, only during vertical blanking, so the pixel datapath never sees a mid-frame position change. It handles edge collisions with clamping and direction reversal, and presents stable `ball_x`/`ball_y` to the ball/hexagon shading logic. It sits between `hvsync_generator` (frame tick decode) and the per-pixel distance datapath.

---
 rtl/ball_motion_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/ball_motion_ctrl.sv
// Frame-synchronous ball position controller: one clamped step per FRAME_DIV frame ticks.
// Optional bounce counter enabled by defining BALL_MOTION_BOUNCE_CNT_EN.
module ball_motion_ctrl #(
   parameter int unsigned H_RES     = 640,
   parameter int unsigned V_RES     = 480,
   parameter int unsigned RADIUS    = 100,
   parameter int unsigned X_INIT    = 320,
   parameter int unsigned Y_INIT    = 240,
   parameter int unsigned FRAME_DIV = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_start,
   input  logic       pause,
   input  logic [1:0] speed,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic       dir_x,
   output logic       dir_y,
   output logic [1:0] bounce,
   output logic       busy,
   output logic [7:0] bounce_count
);

   localparam logic [10:0] XMin    = 11'(RADIUS);
   localparam logic [10:0] XMax    = 11'(H_RES - 1 - RADIUS);
   localparam logic [10:0] YMin    = 11'(RADIUS);
   localparam logic [10:0] YMax    = 11'(V_RES - 1 - RADIUS);
   localparam logic [7:0]  DivLast = 8'(FRAME_DIV - 1);
   localparam logic [9:0]  XReset  = 10'(X_INIT);
   localparam logic [9:0]  YReset  = 10'(Y_INIT);

   typedef enum logic [1:0] {StIdle, StStepX, StStepY, StCommit} state_e;

   state_e      state_q, state_d;
   logic [7:0]  div_q, div_d;
   logic [2:0]  step_q, step_d;
   logic [10:0] nx_q, nx_d, ny_q, ny_d;
   logic        ndx_q, ndx_d, ndy_q, ndy_d;
   logic        hit_x_q, hit_x_d, hit_y_q, hit_y_d;
   logic [9:0]  x_q, x_d, y_q, y_d;
   logic        dx_q, dx_d, dy_q, dy_d;
   logic [1:0]  bounce_q, bounce_d;
   logic        busy_q, busy_d;

   logic [10:0] x_ext, y_ext, step_ext;

   assign x_ext    = {1'b0, x_q};
   assign y_ext    = {1'b0, y_q};
   assign step_ext = {8'd0, step_q};

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      step_d   = step_q;
      nx_d     = nx_q;
      ny_d     = ny_q;
      ndx_d    = ndx_q;
      ndy_d    = ndy_q;
      hit_x_d  = hit_x_q;
      hit_y_d  = hit_y_q;
      x_d      = x_q;
      y_d      = y_q;
      dx_d     = dx_q;
      dy_d     = dy_q;
      bounce_d = 2'b00;
      busy_d   = busy_q;
      unique case (state_q)
         StIdle: begin
            if (frame_start) begin
               if (pause) begin
                  div_d = 8'd0;
               end else if (div_q == DivLast) begin
                  div_d   = 8'd0;
                  step_d  = {1'b0, speed} + 3'd1;
                  busy_d  = 1'b1;
                  state_d = StStepX;
               end else begin
                  div_d = div_q + 8'd1;
               end
            end
         end
         StStepX: begin
            if (dx_q) begin
               if (x_ext + step_ext >= XMax) begin
                  nx_d = XMax; ndx_d = 1'b0; hit_x_d = 1'b1;
               end else begin
                  nx_d = x_ext + step_ext; ndx_d = 1'b1; hit_x_d = 1'b0;
               end
            end else begin
               if (x_ext <= XMin + step_ext) begin
                  nx_d = XMin; ndx_d = 1'b1; hit_x_d = 1'b1;
               end else begin
                  nx_d = x_ext - step_ext; ndx_d = 1'b0; hit_x_d = 1'b0;
               end
            end
            state_d = StStepY;
         end
         StStepY: begin
            if (dy_q) begin
               if (y_ext + step_ext >= YMax) begin
                  ny_d = YMax; ndy_d = 1'b0; hit_y_d = 1'b1;
               end else begin
                  ny_d = y_ext + step_ext; ndy_d = 1'b1; hit_y_d = 1'b0;
               end
            end else begin
               if (y_ext <= YMin + step_ext) begin
                  ny_d = YMin; ndy_d = 1'b1; hit_y_d = 1'b1;
               end else begin
                  ny_d = y_ext - step_ext; ndy_d = 1'b0; hit_y_d = 1'b0;
               end
            end
            state_d = StCommit;
         end
         StCommit: begin
            // Staged values are clamped to the visible range, so the top bit is always 0
            x_d      = nx_q[9:0];
            y_d      = ny_q[9:0];
            dx_d     = ndx_q;
            dy_d     = ndy_q;
            bounce_d = {hit_y_q, hit_x_q};
            busy_d   = 1'b0;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         div_q    <= 8'd0;
         step_q   <= 3'd0;
         nx_q     <= 11'd0;
         ny_q     <= 11'd0;
         ndx_q    <= 1'b0;
         ndy_q    <= 1'b0;
         hit_x_q  <= 1'b0;
         hit_y_q  <= 1'b0;
         x_q      <= XReset;
         y_q      <= YReset;
         dx_q     <= 1'b1;
         dy_q     <= 1'b1;
         bounce_q <= 2'b00;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         step_q   <= step_d;
         nx_q     <= nx_d;
         ny_q     <= ny_d;
         ndx_q    <= ndx_d;
         ndy_q    <= ndy_d;
         hit_x_q  <= hit_x_d;
         hit_y_q  <= hit_y_d;
         x_q      <= x_d;
         y_q      <= y_d;
         dx_q     <= dx_d;
         dy_q     <= dy_d;
         bounce_q <= bounce_d;
         busy_q   <= busy_d;
      end
   end

`ifdef BALL_MOTION_BOUNCE_CNT_EN
   logic [7:0] cnt_q;

   // A corner hit is a single event, hence the OR of both flags
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= 8'd0;
      end else if (state_q == StCommit && (hit_x_q || hit_y_q)) begin
         cnt_q <= cnt_q + 8'd1;
      end
   end

   assign bounce_count = cnt_q;
`else
   assign bounce_count = 8'd0;
`endif

   assign ball_x = x_q;
   assign ball_y = y_q;
   assign dir_x  = dx_q;
   assign dir_y  = dy_q;
   assign bounce = bounce_q;
   assign busy   = busy_q;

endmodule
